// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo slice.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 7;

  // Number of entries addressed by a pointer of the given width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage for sync_fifo: one write port and one registered read port.
// The array itself is never reset; only the read register clears on rst_n,
// so data_out of the FIFO starts from zero.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the accepted word, no reset on the array.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  // Registered read port: load on an accepted read, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy counter.
// Pointers, count and status flags live here; storage is in sync_fifo_ram.
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow outputs, cleared only by rst_n.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                  DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come straight from the registered count; acceptance uses them,
  // so a write on empty never falls through and a write on full is dropped.
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (wr_acc),
    .w_addr (wr_ptr),
    .w_data (data_in),
    .r_en   (rd_acc),
    .r_addr (rd_ptr),
    .r_data (data_out)
  );

  // Pointers advance on accepted transfers and wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: up on write only, down on read only, else unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags: any request made against the blocking flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill, drain, concurrent traffic,
// empty/full boundaries with both enables, pointer wrap, mid-stream reset.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 7;

  logic          clk;
  logic          rst_n;
  logic          w_en;
  logic [DW-1:0] data_in;
  logic          r_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int vectors;
  int miscompares;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .data_in   (data_in),
    .r_en      (r_en),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = '0;

    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_dout",  32'(data_out), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow),  32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("idle_count", 32'(count), 32'd0);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_dout",  32'(data_out), 32'd0);

    // ---------------- fill 0..127 ----------------
    w_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      data_in = DW'(i);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_full",  32'(full),  (i == 127) ? 32'd1 : 32'd0);
    end
    data_in = 8'd200;
    tick();
    check("drop_count", 32'(count), 32'd128);
    check("drop_full",  32'(full),  32'd1);
    check("drop_dout",  32'(data_out), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("drop_ovf", 32'(overflow), 32'd1);
`endif
    w_en = 1'b0;

    // ---------------- drain ----------------
    r_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tick();
      check("drain_dout",  32'(data_out), 32'(i));
      check("drain_count", 32'(count), 32'(127 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    tick();
    check("under_dout",  32'(data_out), 32'd127);
    check("under_count", 32'(count), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("under_udf", 32'(underflow), 32'd1);
`endif
    r_en = 1'b0;

    // ---------------- empty with both enables ----------------
    w_en = 1'b1;
    r_en = 1'b1;
    data_in = 8'hA5;
    tick();
    check("eboth_count", 32'(count), 32'd1);
    check("eboth_dout",  32'(data_out), 32'd127);
    check("eboth_empty", 32'(empty), 32'd0);
    r_en = 1'b0;

    // top up to 5 words: A5,10,11,12,13
    for (int i = 0; i < 4; i++) begin
      data_in = DW'(8'h10 + i);
      tick();
    end
    check("pre_conc_count", 32'(count), 32'd5);

    // ---------------- concurrent read/write, crosses pointer wrap ----------------
    r_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      logic [DW-1:0] exp_d;
      data_in = DW'(8'h20 + k);
      tick();
      case (k)
        0:       exp_d = 8'hA5;
        1:       exp_d = 8'h10;
        2:       exp_d = 8'h11;
        3:       exp_d = 8'h12;
        4:       exp_d = 8'h13;
        default: exp_d = DW'(8'h20 + k - 5);
      endcase
      check("conc_dout",  32'(data_out), 32'(exp_d));
      check("conc_count", 32'(count), 32'd5);
    end
    r_en = 1'b0;
    // FIFO now holds 1B,1C,1D,1E,1F

    // ---------------- fill to full, then both enables ----------------
    for (int j = 0; j < 123; j++) begin
      data_in = DW'(8'h40 + j);
      tick();
    end
    check("refill_count", 32'(count), 32'd128);
    check("refill_full",  32'(full),  32'd1);
    r_en = 1'b1;
    data_in = 8'hEE;
    tick();
    check("fboth_count", 32'(count), 32'd127);
    check("fboth_dout",  32'(data_out), 32'h1B);
    check("fboth_full",  32'(full), 32'd0);
    w_en = 1'b0;
    for (int i = 0; i < 127; i++) begin
      logic [DW-1:0] exp_d;
      tick();
      exp_d = (i < 4) ? DW'(8'h1C + i) : DW'(8'h40 + i - 4);
      check("fdrain_dout", 32'(data_out), 32'(exp_d));
    end
    check("fdrain_count", 32'(count), 32'd0);
    check("fdrain_empty", 32'(empty), 32'd1);
    r_en = 1'b0;

    // ---------------- asynchronous reset mid-stream ----------------
    w_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      data_in = DW'(8'h80 + i);
      tick();
    end
    w_en = 1'b0;
    check("mid_count", 32'(count), 32'd60);
    check("mid_dout",  32'(data_out), 32'hBA);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_dout",  32'(data_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w_en = 1'b1;
    data_in = 8'h5A;
    tick();
    w_en = 1'b0;
    check("post_wr_count", 32'(count), 32'd1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("post_rd_dout",  32'(data_out), 32'h5A);
    check("post_rd_count", 32'(count), 32'd0);
    check("post_rd_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
